// File: rtl/vsr_pkg.sv
// vsr_pkg: shared encodings for versatile_shift_reg and its shift core.
//   MODE_*    : 3-bit operation codes used on the mode port and the core op input
//   S_IDLE/S_BURST : burst FSM states
//   DIR_*     : burst direction values
package vsr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } vsr_state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/vsr_shift_core.sv
// vsr_shift_core: combinational next-value generator for the shift register.
// Ports:
//   q        in  WIDTH  current register value
//   op       in  3      operation code (vsr_pkg MODE_*); 111 acts as hold
//   ser_in_l in  1      bit entering at the MSB on SHR
//   ser_in_r in  1      bit entering at the LSB on SHL
//   par_in   in  WIDTH  parallel load data
//   q_next   out WIDTH  value the register takes for this op
module vsr_shift_core
    import vsr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            MODE_LOAD: q_next = par_in;
            MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/versatile_shift_reg.sv
// versatile_shift_reg: WIDTH-bit register with single-cycle shift/rotate/load
// modes and a self-timed burst engine that shifts burst_len times per start.
// Optional macro VSR_PARITY_EN adds a registered parity output (== ^q).
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   en, mode, par_in    single-cycle operation controls (IDLE only)
//   ser_in_l, ser_in_r  serial inputs at MSB / LSB
//   start, burst_dir, burst_len   burst request
//   q, ser_out_l, ser_out_r       register contents and its end bits
//   busy, done          burst handshake
//   parity              (VSR_PARITY_EN only) XOR reduction of q
//
// state   | meaning
// S_IDLE  | single-cycle modes apply; start launches a burst
// S_BURST | one shift per edge until the counter reaches 1
module versatile_shift_reg
    import vsr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    input  logic             burst_dir,
    input  logic [CW-1:0]    burst_len,
    output logic [WIDTH-1:0] q,
`ifdef VSR_PARITY_EN
    output logic             parity,
`endif
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    vsr_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       core_op;
    logic [WIDTH-1:0] core_next;

    // During a burst the core is driven as a plain SHL/SHR so the serial
    // inputs enter exactly as they would in the single-cycle modes.
    always_comb begin
        if (state_q == S_BURST) begin
            core_op = (dir_q == DIR_LEFT) ? MODE_SHL : MODE_SHR;
        end else begin
            core_op = en ? mode : MODE_HOLD;
        end
    end

    vsr_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .q        (q_q),
        .op       (core_op),
        .ser_in_l (ser_in_l),
        .ser_in_r (ser_in_r),
        .par_in   (par_in),
        .q_next   (core_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        cnt_d   = (burst_len > WIDTH_C) ? WIDTH_C : burst_len;
                        dir_d   = burst_dir;
                        busy_d  = 1'b1;
                    end
                end else if (en) begin
                    q_d = core_next;
                end
            end
            S_BURST: begin
                q_d   = core_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef VSR_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q         = q_q;
    assign ser_out_l = q_q[WIDTH-1];
    assign ser_out_r = q_q[0];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_versatile_shift_reg.sv
module tb_versatile_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  par_in = '0;
    logic          ser_in_l = 1'b0;
    logic          ser_in_r = 1'b0;
    logic          start = 1'b0;
    logic          burst_dir = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic [W-1:0]  q;
    logic          ser_out_l, ser_out_r, busy, done;
`ifdef VSR_PARITY_EN
    logic          parity;
`endif

    versatile_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .par_in    (par_in),
        .ser_in_l  (ser_in_l),
        .ser_in_r  (ser_in_r),
        .start     (start),
        .burst_dir (burst_dir),
        .burst_len (burst_len),
        .q         (q),
`ifdef VSR_PARITY_EN
        .parity    (parity),
`endif
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: register value, remaining burst shifts, latched direction.
    int unsigned m_q;
    int          m_rem = 0;
    bit          m_dir = 1'b0;
    bit          m_done = 1'b0;

    always @(posedge clk) begin
        int n;
        if (reset) begin
            m_q = 0; m_rem = 0; m_done = 0;
        end else if (m_rem > 0) begin
            if (m_dir) m_q = ((m_q << 1) | ser_in_r) & 32'hFF;
            else       m_q = (m_q >> 1) | (ser_in_l ? 32'h80 : 0);
            m_rem--;
            m_done = (m_rem == 0);
        end else if (start) begin
            n = (int'(burst_len) > W) ? W : int'(burst_len);
            m_done = (n == 0);
            m_rem = n;
            m_dir = burst_dir;
        end else begin
            m_done = 0;
            if (en) begin
                case (mode)
                    3'd1: m_q = par_in;
                    3'd2: m_q = ((m_q << 1) | ser_in_r) & 32'hFF;
                    3'd3: m_q = (m_q >> 1) | (ser_in_l ? 32'h80 : 0);
                    3'd4: m_q = ((m_q << 1) | (m_q >> 7)) & 32'hFF;
                    3'd5: m_q = ((m_q >> 1) | (m_q << 7)) & 32'hFF;
                    3'd6: m_q = (m_q >> 1) | (m_q & 32'h80);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", 32'(q), m_q);
            check("model_busy", 32'(busy), 32'(m_rem > 0));
            check("model_done", 32'(done), 32'(m_done));
            check("model_ser_out_l", 32'(ser_out_l), (m_q >> 7) & 1);
            check("model_ser_out_r", 32'(ser_out_r), m_q & 1);
`ifdef VSR_PARITY_EN
            check("model_parity", 32'(parity), 32'($countones(m_q) & 1));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] m, input logic [W-1:0] d);
        en = 1'b1; mode = m; par_in = d;
        tick();
        en = 1'b0; mode = 3'b000;
    endtask

    initial begin
        int busy_cnt;
        bit got_done;

        @(negedge clk);
        tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset behaviour
        op(3'd1, 8'h5A);
        check("load_5a", 32'(q), 32'h5A);
        reset = 1'b1;
        #1;
        check("reset_no_edge", 32'(q), 32'h5A);
        tick();
        check("reset_q", 32'(q), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        reset = 1'b0;

        // Single-cycle modes
        op(3'd1, 8'hA5);
        check("load_a5", 32'(q), 32'hA5);
        check("ser_out_l_a5", 32'(ser_out_l), 1);
        ser_in_r = 1'b1;
        op(3'd2, '0);
        ser_in_r = 1'b0;
        check("shl_4b", 32'(q), 32'h4B);
        op(3'd5, '0);
        check("ror_a5", 32'(q), 32'hA5);
        op(3'd1, 8'h80);
        op(3'd6, '0);
        check("asr_c0", 32'(q), 32'hC0);
        op(3'd7, '0);
        check("reserved_hold", 32'(q), 32'hC0);

        // Right burst of 4 with mode/en noise
        op(3'd1, 8'hF0);
        start = 1'b1; burst_dir = 1'b0; burst_len = 4'd4; ser_in_l = 1'b0;
        tick();
        start = 1'b0;
        check("burst_start_q", 32'(q), 32'hF0);
        busy_cnt = 0;
        got_done = 0;
        for (int i = 0; i < 12 && !got_done; i++) begin
            if (busy) busy_cnt++;
            en = ~en; mode = 3'(i); par_in = 8'h33; start = 1'b1;
            tick();
            got_done = done;
        end
        en = 1'b0; start = 1'b0;
        check("burst4_busy_cycles", 32'(busy_cnt), 4);
        check("burst4_done", 32'(got_done), 1);
        check("burst4_q", 32'(q), 32'h0F);
        tick();
        check("burst4_done_once", 32'(done), 0);

        // Zero-length burst
        start = 1'b1; burst_len = '0;
        tick();
        start = 1'b0;
        check("len0_busy", 32'(busy), 0);
        check("len0_done", 32'(done), 1);
        check("len0_q", 32'(q), 32'h0F);
        tick();
        check("len0_done_clear", 32'(done), 0);

        // Clamped burst: 15 -> 8 shifts
        op(3'd1, 8'hFF);
        start = 1'b1; burst_dir = 1'b0; burst_len = 4'd15; ser_in_l = 1'b0;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        got_done = 0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (busy) busy_cnt++;
            tick();
            got_done = done;
        end
        check("clamp_done", 32'(got_done), 1);
        check("clamp_busy_cycles", 32'(busy_cnt), 8);
        check("clamp_q", 32'(q), 0);

        // Reset on the 2nd cycle of a 6-shift burst
        op(3'd1, 8'hFF);
        start = 1'b1; burst_dir = 1'b1; burst_len = 4'd6; ser_in_r = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("abort_pre_q", 32'(q), 32'hFE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_q", 32'(q), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        start = 1'b1; burst_dir = 1'b0; burst_len = 4'd2; ser_in_l = 1'b1;
        tick();
        start = 1'b0;
        check("abort_no_done", 32'(done), 0);
        tick();
        tick();
        check("restart_done", 32'(done), 1);
        check("restart_q", 32'(q), 32'hC0);
        ser_in_l = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            en        = 1'($urandom);
            mode      = 3'($urandom);
            par_in    = 8'($urandom);
            ser_in_l  = 1'($urandom);
            ser_in_r  = 1'($urandom);
            start     = ($urandom_range(0, 7) == 0);
            burst_dir = 1'($urandom);
            burst_len = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0; start = 1'b0; en = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
